// File: rtl/adder_error_monitor_if.sv
// Result-pair stream and measurement-report bundle between the adder pair,
// the error monitor and its controller.
interface adder_error_monitor_if #(
  parameter int WIDTH        = 16,
  parameter int SAMPLES_LOG2 = 10
);
  logic                           start;
  logic                           in_valid;
  logic                           in_ready;
  logic [WIDTH:0]                 exact_res;
  logic [WIDTH:0]                 approx_res;
  logic                           busy;
  logic                           done;
  logic [SAMPLES_LOG2:0]          err_count;
  logic [WIDTH+SAMPLES_LOG2:0]    sum_ed;
  logic [WIDTH:0]                 max_ed;
  logic [SAMPLES_LOG2:0]          sample_cnt;

  modport master (
    output start, in_valid, exact_res, approx_res,
    input  in_ready, busy, done, err_count, sum_ed, max_ed, sample_cnt
  );

  modport slave (
    input  start, in_valid, exact_res, approx_res,
    output in_ready, busy, done, err_count, sum_ed, max_ed, sample_cnt
  );
endinterface

// File: rtl/adder_error_monitor.sv
// Windowed error-metric accumulator for exact vs approximate adder results:
// error count, summed and maximum absolute error distance over 2^SAMPLES_LOG2 pairs.
module adder_error_monitor #(
  parameter int WIDTH        = 16,
  parameter int SAMPLES_LOG2 = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_error_monitor_if.slave mon
);
  localparam int RW = WIDTH + 1;
  localparam int CW = SAMPLES_LOG2 + 1;
  localparam int SW = WIDTH + 1 + SAMPLES_LOG2;
  localparam logic [CW-1:0] N = {1'b1, {SAMPLES_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic           in_ready, accept, clr;
  logic [RW-1:0]  ed_d, ed_q, max_q;
  logic           mis_q, s1_valid;
  logic [CW-1:0]  cnt_q, err_q;
  logic [SW-1:0]  sum_q;

  assign in_ready = (state == RUN) && (cnt_q != N);
  assign accept   = mon.in_valid && in_ready;
  assign clr      = (state == IDLE) && mon.start;
  assign ed_d     = (mon.exact_res >= mon.approx_res) ? mon.exact_res - mon.approx_res
                                                      : mon.approx_res - mon.exact_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mon.start) state_nxt = RUN;
      RUN:     if (accept && cnt_q == N - 1'b1) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1: distance and mismatch flag of the accepted pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      ed_q     <= '0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        ed_q  <= ed_d;
        mis_q <= (mon.exact_res != mon.approx_res);
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Stage 2: accumulators; the last sample lands on the DRAIN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else if (clr) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else if (s1_valid) begin
      err_q <= err_q + CW'(mis_q);
      sum_q <= sum_q + SW'(ed_q);
      if (ed_q > max_q) max_q <= ed_q;
    end
  end

  assign mon.in_ready   = in_ready;
  assign mon.busy       = (state == RUN) || (state == DRAIN);
  assign mon.done       = (state == DONE);
  assign mon.err_count  = err_q;
  assign mon.sum_ed     = sum_q;
  assign mon.max_ed     = max_q;
  assign mon.sample_cnt = cnt_q;
endmodule

// File: tb/tb_adder_error_monitor.sv
// Randomized and directed windows against a queue-based metric model.
module tb_adder_error_monitor;
  localparam int W  = 16;
  localparam int SL = 2;
  localparam int N  = 1 << SL;

  typedef logic [W:0] word_t;
  typedef word_t win_t [N];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_error_monitor_if #(.WIDTH(W), .SAMPLES_LOG2(SL)) mif ();
  adder_error_monitor #(.WIDTH(W), .SAMPLES_LOG2(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mif.slave)
  );

  int checks = 0;
  int fails  = 0;
  word_t qe[$], qa[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Metrics over the first n accepted pairs, straight from the definitions.
  task automatic chk_metrics(input string tag, input int n);
    int unsigned ec = 0, mx = 0;
    longint unsigned se = 0;
    for (int i = 0; i < n; i++) begin
      int d = int'(qe[i]) - int'(qa[i]);
      if (d < 0) d = -d;
      if (d != 0) ec++;
      se += longint'(d);
      if (d > int'(mx)) mx = d;
    end
    chk({tag, ".err"}, mif.err_count, ec);
    chk({tag, ".sum"}, mif.sum_ed, se);
    chk({tag, ".max"}, mif.max_ed, mx);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rdy"},  mif.in_ready, 0);
    chk({tag, ".busy"}, mif.busy, 0);
    chk({tag, ".done"}, mif.done, 0);
    chk({tag, ".err"},  mif.err_count, 0);
    chk({tag, ".sum"},  mif.sum_ed, 0);
    chk({tag, ".max"},  mif.max_ed, 0);
    chk({tag, ".cnt"},  mif.sample_cnt, 0);
  endtask

  // mode 0: always valid, 1: fixed 1,0,0,1,1,0,1 pattern with a mid-RUN start, 2: random gaps
  task automatic run_window(input string tag, input win_t ex, input win_t ap, input int mode);
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int k = 0, cyc = 0;
    bit v, last_acc = 0;
    qe.delete(); qa.delete();
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    chk({tag, ".run_busy"}, mif.busy, 1);
    chk_metrics({tag, ".clr"}, 0);
    chk({tag, ".clr_cnt"}, mif.sample_cnt, 0);
    while (k < N && cyc < 200) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 7] : 1'($urandom_range(0, 1));
      mif.in_valid   = v;
      mif.exact_res  = v ? ex[k] : word_t'($urandom);
      mif.approx_res = v ? ap[k] : word_t'($urandom);
      mif.start      = (mode == 1) && (cyc == 2);
      chk({tag, ".rdy"}, mif.in_ready, 1);
      @(negedge clk);
      cyc++;
      if (v) begin
        qe.push_back(ex[k]);
        qa.push_back(ap[k]);
        k++;
      end
      last_acc = v;
      chk({tag, ".cnt"}, mif.sample_cnt, k);
      chk_metrics({tag, ".lat"}, last_acc ? k - 1 : k);
    end
    if (k < N) chk({tag, ".timeout"}, k, N);
    mif.start      = 1'b0;
    mif.in_valid   = 1'b1;
    mif.exact_res  = word_t'($urandom);
    mif.approx_res = word_t'($urandom);
    chk({tag, ".drain_busy"}, mif.busy, 1);
    chk({tag, ".drain_done"}, mif.done, 0);
    chk({tag, ".drain_rdy"},  mif.in_ready, 0);
    @(negedge clk);
    chk({tag, ".done"},      mif.done, 1);
    chk({tag, ".done_busy"}, mif.busy, 0);
    chk({tag, ".done_rdy"},  mif.in_ready, 0);
    chk({tag, ".done_cnt"},  mif.sample_cnt, N);
    chk_metrics({tag, ".res"}, N);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({tag, ".idle_done"}, mif.done, 0);
      chk({tag, ".idle_busy"}, mif.busy, 0);
      chk({tag, ".idle_cnt"},  mif.sample_cnt, N);
      chk_metrics({tag, ".hold"}, N);
    end
    mif.in_valid = 1'b0;
  endtask

  initial begin
    win_t ex, ap;
    mif.start = 1'b0; mif.in_valid = 1'b0;
    mif.exact_res = '0; mif.approx_res = '0;

    #2 chk_zero("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    mif.in_valid = 1'b1;
    mif.exact_res = 17'h1FFFF;
    repeat (3) @(negedge clk);
    chk_zero("idle");
    mif.in_valid = 1'b0;

    for (int i = 0; i < N; i++) begin ex[i] = 17'h0B53F; ap[i] = 17'h0B53F; end
    run_window("match", ex, ap, 0);

    ex = '{17'h10000, 17'h0FFFF, 17'h12345, 17'h00010};
    ap = '{17'h0FFFF, 17'h0FFFF, 17'h12349, 17'h00000};
    run_window("mixed", ex, ap, 0);

    for (int i = 0; i < N; i++) begin ex[i] = 17'h1FFFF; ap[i] = 17'h00000; end
    run_window("extreme", ex, ap, 0);

    for (int i = 0; i < N; i++) begin ex[i] = word_t'($urandom); ap[i] = ex[i] ^ word_t'(1 << i); end
    run_window("stall", ex, ap, 1);

    // Mid-window reset after two accepts
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    mif.in_valid = 1'b1;
    mif.exact_res = 17'h00100; mif.approx_res = 17'h00000;
    repeat (2) @(negedge clk);
    mif.in_valid = 1'b0;
    chk("mid.cnt", mif.sample_cnt, 2);
    rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < N; i++) begin
        ex[i] = word_t'($urandom);
        case ($urandom_range(0, 2))
          0:       ap[i] = ex[i];
          1:       ap[i] = ex[i] ^ word_t'($urandom_range(0, 255));
          default: ap[i] = word_t'($urandom);
        endcase
      end
      run_window($sformatf("rnd%0d", w), ex, ap, (w % 2 == 0) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
endmodule
